thermostat_ctrl: RTL and testbench

Closed-loop thermostat that generates the heat request `A` and cool request `B` consumed by the heating unit FSM. It also monitors that unit's status LEDs (`LR` = heating, `LG` = cooling) as acknowledgements. The block compares the latest temperature sample against a setpoint with symmetric hysteresis and enforces a minimum dwell time in every state. It detects a missing or conflicting acknowledgement and enters a timed lockout with `fault` raised.

---
 rtl/thermostat_ctrl.sv | 154 +++++++++++++++
 tb/tb_thermostat_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/thermostat_ctrl.sv
// rtl/thermostat_ctrl.sv - hysteresis thermostat driving heat/cool requests
// Supervises the heating unit's LR/LG acknowledgements and locks out on timeout or conflict.
module thermostat_ctrl #(
  parameter int TEMP_W         = 8,
  parameter int MIN_DWELL      = 16,
  parameter int ACK_TIMEOUT    = 8,
  parameter int LOCKOUT_CYCLES = 32
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     enable,
  input  logic signed [TEMP_W-1:0] temp,
  input  logic                     temp_valid,
  input  logic signed [TEMP_W-1:0] setpoint,
  input  logic        [TEMP_W-1:0] hyst,
  input  logic                     LR,
  input  logic                     LG,
  output logic                     A,
  output logic                     B,
  output logic                     fault
);
  localparam int XW = TEMP_W + 2;
  localparam int DW = $clog2(MIN_DWELL + 1);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL);
  localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEAT,
    S_COOL,
    S_LOCKOUT
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic signed [TEMP_W-1:0]  r_temp_q;
  logic                      r_seen;
  logic [DW-1:0]             r_dwell_cnt;
  logic [AW-1:0]             r_ack_cnt;
  logic                      r_acked;
  logic [LW-1:0]             r_lock_cnt;
  logic                      r_a;
  logic                      r_b;
  logic                      r_fault;

  logic signed [XW-1:0]      w_temp_x;
  logic signed [XW-1:0]      w_low;
  logic signed [XW-1:0]      w_high;
  logic                      w_cold;
  logic                      w_hot;
  logic                      w_dwell_met;
  logic                      w_entry;
  logic                      w_supervised;
  logic                      w_ack_in;
  logic                      w_conflict;
  logic                      w_satisfied;

  // Two guard bits keep setpoint +/- hyst exact for any signed setpoint and unsigned hyst.
  assign w_temp_x = {{2{r_temp_q[TEMP_W-1]}}, r_temp_q};
  assign w_low    = {{2{setpoint[TEMP_W-1]}}, setpoint} - {2'b00, hyst};
  assign w_high   = {{2{setpoint[TEMP_W-1]}}, setpoint} + {2'b00, hyst};
  assign w_cold   = r_seen && (w_temp_x < w_low);
  assign w_hot    = r_seen && (w_temp_x > w_high);

  assign w_dwell_met  = (r_dwell_cnt == DWELL_MAX);
  assign w_entry      = (w_state_nxt != r_state);
  assign w_supervised = (r_state == S_HEAT) || (r_state == S_COOL);
  assign w_ack_in     = (r_state == S_HEAT) ? LR : LG;
  assign w_conflict   = (r_state == S_HEAT) ? LG : LR;
  assign w_satisfied  = (r_state == S_HEAT) ? (r_temp_q >= setpoint) : (r_temp_q <= setpoint);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (enable && w_dwell_met && w_cold) begin
          w_state_nxt = S_HEAT;
        end else if (enable && w_dwell_met && w_hot) begin
          w_state_nxt = S_COOL;
        end
      end
      S_HEAT, S_COOL: begin
        if (w_conflict) begin
          w_state_nxt = S_LOCKOUT;
        end else if (!r_acked && !w_ack_in && (r_ack_cnt == ACK_LAST)) begin
          w_state_nxt = S_LOCKOUT;
        end else if (!enable) begin
          w_state_nxt = S_IDLE;
        end else if (w_dwell_met && w_satisfied) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (r_lock_cnt == LOCK_LAST) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_temp_q    <= '0;
      r_seen      <= 1'b0;
      r_dwell_cnt <= '0;
      r_ack_cnt   <= '0;
      r_acked     <= 1'b0;
      r_lock_cnt  <= '0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= (w_state_nxt == S_HEAT);
      r_b     <= (w_state_nxt == S_COOL);
      r_fault <= (w_state_nxt == S_LOCKOUT);
      if (temp_valid) begin
        r_temp_q <= temp;
        r_seen   <= 1'b1;
      end
      if (w_entry) begin
        r_dwell_cnt <= '0;
        r_ack_cnt   <= '0;
        r_acked     <= 1'b0;
        r_lock_cnt  <= '0;
      end else begin
        if (!w_dwell_met) begin
          r_dwell_cnt <= r_dwell_cnt + 1'b1;
        end
        if (r_state == S_LOCKOUT) begin
          r_lock_cnt <= r_lock_cnt + 1'b1;
        end
        if (w_supervised) begin
          if (w_ack_in) begin
            r_acked <= 1'b1;
          end
          if (!r_acked) begin
            r_ack_cnt <= r_ack_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign A     = r_a;
  assign B     = r_b;
  assign fault = r_fault;

endmodule

// File: tb/tb_thermostat_ctrl.sv
// tb/tb_thermostat_ctrl.sv - bench for thermostat_ctrl
// Directed scenarios then random traffic, every edge compared with an edge-age reference model.
module tb_thermostat_ctrl;
  localparam int MD = 16;
  localparam int AT = 8;
  localparam int LC = 32;
  localparam int M_IDLE = 0;
  localparam int M_HEAT = 1;
  localparam int M_COOL = 2;
  localparam int M_LOCK = 3;

  logic              clock = 1'b0;
  logic              rst;
  logic              enable;
  logic signed [7:0] temp;
  logic              temp_valid;
  logic signed [7:0] setpoint;
  logic        [7:0] hyst;
  logic              LR;
  logic              LG;
  logic              A;
  logic              B;
  logic              fault;

  int checks   = 0;
  int failures = 0;

  int m_mode;
  int m_age;
  int m_tq;
  bit m_ack;
  bit m_seen;

  always #5 clock = ~clock;

  thermostat_ctrl #(
    .TEMP_W(8), .MIN_DWELL(MD), .ACK_TIMEOUT(AT), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clock(clock), .rst(rst), .enable(enable), .temp(temp), .temp_valid(temp_valid),
    .setpoint(setpoint), .hyst(hyst), .LR(LR), .LG(LG), .A(A), .B(B), .fault(fault)
  );

  // Single age counter per visit: dwell, ack window and lockout length all derive from it.
  function automatic void model_edge();
    int sp, hy, nxt;
    bit cold, hot, met, conf, ack_in, done;
    sp = int'(setpoint);
    hy = int'(hyst);
    if (rst) begin
      m_mode = M_IDLE; m_age = 0; m_ack = 1'b0; m_tq = 0; m_seen = 1'b0;
      return;
    end
    cold = m_seen && (m_tq < sp - hy);
    hot  = m_seen && (m_tq > sp + hy);
    met  = (m_age >= MD);
    nxt  = m_mode;
    conf   = (m_mode == M_HEAT) ? LG : LR;
    ack_in = (m_mode == M_HEAT) ? LR : LG;
    done   = (m_mode == M_HEAT) ? (m_tq >= sp) : (m_tq <= sp);
    if (m_mode == M_IDLE) begin
      if (enable && met && cold) nxt = M_HEAT;
      else if (enable && met && hot) nxt = M_COOL;
    end else if (m_mode == M_LOCK) begin
      if (m_age == LC - 1) nxt = M_IDLE;
    end else begin
      if (conf) nxt = M_LOCK;
      else if (!m_ack && !ack_in && m_age == AT - 1) nxt = M_LOCK;
      else if (!enable) nxt = M_IDLE;
      else if (met && done) nxt = M_IDLE;
    end
    if (temp_valid) begin
      m_tq = int'(temp);
      m_seen = 1'b1;
    end
    if (nxt != m_mode) begin
      m_age = 0;
      m_ack = 1'b0;
    end else begin
      m_age++;
      if (m_mode != M_IDLE && m_mode != M_LOCK && ack_in) m_ack = 1'b1;
    end
    m_mode = nxt;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check("model_A", A, m_mode == M_HEAT);
    check("model_B", B, m_mode == M_COOL);
    check("model_fault", fault, m_mode == M_LOCK);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load(input int t);
    temp = 8'(t);
    temp_valid = 1'b1;
    tick();
    temp_valid = 1'b0;
  endtask

  int sp_r;
  bit broken;

  initial begin
    rst = 1'b1; enable = 1'b1; temp = 8'sd0; temp_valid = 1'b0;
    setpoint = 8'sd20; hyst = 8'd2; LR = 1'b0; LG = 1'b0;
    m_mode = M_IDLE; m_age = 0; m_ack = 1'b0; m_tq = 0; m_seen = 1'b0;
    ticks(2);
    check("reset_A", A, 1'b0);
    check("reset_B", B, 1'b0);
    check("reset_fault", fault, 1'b0);
    rst = 1'b0;

    // First heat request, ack after two cycles, satisfied exit after 17 cycles in HEAT
    ticks(20);
    load(17);
    check("no_req_on_load_edge", A, 1'b0);
    tick();
    check("heat_one_edge_later", A, 1'b1);
    load(21);
    tick();
    LR = 1'b1;
    ticks(14);
    check("heat_held_edge16", A, 1'b1);
    tick();
    check("heat_exit_edge17", A, 1'b0);
    check("heat_exit_no_fault", fault, 1'b0);
    LR = 1'b0;

    // Hysteresis edges
    temp = 8'sd18; temp_valid = 1'b1;
    ticks(20);
    temp_valid = 1'b0;
    check("t18_no_heat", A, 1'b0);
    load(17);
    tick();
    check("t17_heat", A, 1'b1);
    enable = 1'b0;
    tick();
    check("enable_abort", A, 1'b0);
    temp = 8'sd22; temp_valid = 1'b1; enable = 1'b1;
    ticks(20);
    temp_valid = 1'b0;
    check("t22_no_cool", B, 1'b0);
    check("t22_no_heat", A, 1'b0);
    load(23);
    tick();
    check("t23_cool", B, 1'b1);

    // Conflict in COOL
    LG = 1'b1;
    ticks(2);
    LR = 1'b1;
    tick();
    check("conflict_B", B, 1'b0);
    check("conflict_fault", fault, 1'b1);
    LR = 1'b0; LG = 1'b0;
    load(20);
    ticks(30);
    check("lockout_held", fault, 1'b1);
    tick();
    check("lockout_end", fault, 1'b0);

    // Ack timeout, lockout length, re-entry after dwell
    load(17);
    ticks(15);
    check("dwell_not_met", A, 1'b0);
    tick();
    check("dwell_met_heat", A, 1'b1);
    ticks(7);
    check("ack_window_open", fault, 1'b0);
    tick();
    check("ack_timeout_A", A, 1'b0);
    check("ack_timeout_fault", fault, 1'b1);
    ticks(31);
    check("timeout_lock_held", fault, 1'b1);
    tick();
    check("timeout_lock_end", fault, 1'b0);
    ticks(16);
    check("reheat_wait", A, 1'b0);
    tick();
    check("reheat", A, 1'b1);
    LR = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    check("enable_abort2", A, 1'b0);

    // Extremes: thresholds must not wrap at 8 bits
    setpoint = 8'sd127; hyst = 8'd5; enable = 1'b1;
    load(-128);
    ticks(20);
    check("extreme_heat", A, 1'b1);
    setpoint = -8'sd128; hyst = 8'd10;
    ticks(20);
    check("extreme_low_no_heat", A, 1'b0);
    ticks(20);
    check("extreme_low_no_heat2", A, 1'b0);
    check("extreme_low_no_cool", B, 1'b0);

    // Reset mid-HEAT clears seen
    setpoint = 8'sd20; hyst = 8'd2;
    load(17);
    for (int i = 0; i < 40 && A !== 1'b1; i++) tick();
    check("pre_reset_heat", A, 1'b1);
    rst = 1'b1;
    tick();
    check("reset_abort_A", A, 1'b0);
    rst = 1'b0; LR = 1'b0;
    ticks(40);
    check("no_req_without_sample", A, 1'b0);
    load(17);
    tick();
    check("fresh_sample_heat", A, 1'b1);
    enable = 1'b0;
    tick();
    enable = 1'b1;

    // Random traffic against the model
    sp_r = 20; broken = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 400 == 0) begin
        sp_r = int'($urandom_range(0, 60)) - 20;
        setpoint = 8'(sp_r);
        hyst = 8'($urandom_range(0, 6));
        broken = ($urandom_range(0, 2) == 0);
      end
      temp = 8'(sp_r + int'($urandom_range(0, 20)) - 10);
      temp_valid = ($urandom_range(0, 9) < 3);
      enable = ($urandom_range(0, 49) != 0);
      rst = ($urandom_range(0, 499) == 0);
      if (broken) begin
        LR = ($urandom_range(0, 29) == 0);
        LG = ($urandom_range(0, 29) == 0);
      end else begin
        LR = (A && $urandom_range(0, 3) != 0) || ($urandom_range(0, 199) == 0);
        LG = (B && $urandom_range(0, 3) != 0) || ($urandom_range(0, 199) == 0);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
